c910_axi_txn_limiter: RTL and testbench
=======================================

C910_AXI_TXN_LIMITER -- requirements
Module: c910_axi_txn_limiter

Interface
REQ-001 SHALL have parameter AxiIdWidth, default 8, meaning width of the AR/R/AW/B ID fields.
REQ-002 SHALL have parameter NcIdBit, default 7, meaning the ID bit that marks a transaction non-cacheable/device (1) or cacheable (0).
REQ-003 SHALL have parameters MaxRdC=28, MaxRdNc=8, MaxWrC=32, MaxWrNc=8, meaning the outstanding limits per class and direction.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 ar_valid_i/ar_ready_o  in/out  1  AR handshake toward the C910 master.
REQ-006a ar_id_i  in  AxiIdWidth  AR ID.
REQ-007 ar_valid_o/ar_ready_i  out/in  1  AR handshake toward the crossbar.
REQ-008 r_valid_i, r_ready_i, r_last_i  in  1  R-channel snoop.
REQ-008a r_id_i  in  AxiIdWidth  R ID.
REQ-009 aw_valid_i/aw_ready_o and aw_valid_o/aw_ready_i  same as AR.
REQ-009a aw_id_i  in  AxiIdWidth  AW ID.
REQ-010 b_valid_i, b_ready_i  in  1  B-channel snoop.
REQ-010a b_id_i  in  AxiIdWidth  B ID.
REQ-011 flush_req_i  in  1  request to quiesce; flush_ack_o  out  1  quiesced.
REQ-012 err_o  out  1  sticky counter-underflow error.
REQ-013 rd_cnt_c_o, rd_cnt_nc_o, wr_cnt_c_o, wr_cnt_nc_o  out  $clog2(Max+1) each  live outstanding counts.
REQ-014 stall_cycles_o  out  32  statistics output (see Configuration).

Function
REQ-015 Class SHALL be taken from ID bit NcIdBit on request and response channels alike.
REQ-016 ar_valid_o = ar_valid_i & ~ar_block and ar_ready_o = ar_ready_i & ~ar_block, where ar_block = (class counter == its Max) | flush state != IDLE; combinational, zero latency.
REQ-017 AW gating SHALL be identical using the write counters.
REQ-018 The read counter of a class SHALL increment on an accepted AR (ar_valid_o & ar_ready_i) and decrement on an R beat with r_valid_i & r_ready_i & r_last_i; non-last beats SHALL NOT decrement.
REQ-019 The write counter of a class SHALL increment on an accepted AW and decrement on a B handshake.
REQ-020 Simultaneous increment and decrement of the same counter SHALL leave it unchanged.
REQ-021 A counter at Max SHALL never exceed Max; an AR of that class is blocked, while the other class is unaffected.
REQ-022 A decrement at 0 SHALL leave the counter at 0 and set err_o until reset.
REQ-023 Flush FSM states IDLE, DRAIN, DONE: IDLE->DRAIN on flush_req_i; DRAIN->DONE when all four counters are 0; DONE->IDLE when flush_req_i is low.
REQ-024 flush_ack_o SHALL be 1 only in DONE, registered, and assert the cycle after the counters reach 0.
REQ-025 A handshake already in progress when entering DRAIN SHALL be blocked from the next cycle; valid_o SHALL drop with no accepted transfer counted.

Reset
REQ-026 On rst_ni low, all counters, err_o, flush_ack_o and stall_cycles_o SHALL be 0 and the FSM SHALL be in IDLE, asynchronously.
REQ-027 Reset mid-operation SHALL discard all outstanding state; responses arriving after reset count as underflow.

Configuration
REQ-028 With C910_TXN_STATS_EN defined, stall_cycles_o SHALL count cycles where ar_valid_i or aw_valid_i is blocked by REQ-016/017.
REQ-028a The stall counter SHALL saturate at 0xFFFFFFFF.
REQ-029 Without C910_TXN_STATS_EN, stall_cycles_o SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-030 28 cacheable ARs with id[7]=0 and no R -> rd_cnt_c_o=28 and the 29th cacheable AR is blocked, while a nc AR with id[7]=1 still passes and rd_cnt_nc_o=1.
REQ-031 A 4-beat R burst -> the counter decrements by exactly 1, on the r_last_i beat.
REQ-032 AR accept and R last of the same class in one cycle with count 5 -> count stays 5.
REQ-033 flush_req_i with 3 outstanding writes -> AR/AW blocked and flush_ack_o=0; after the 3rd B, flush_ack_o=1 the next cycle; dropping flush_req_i returns the FSM to IDLE.
REQ-034 A B handshake with wr_cnt_nc_o=0 -> err_o=1 sticky and the counter stays 0.
REQ-035 With C910_TXN_STATS_EN, 10 blocked AR cycles -> stall_cycles_o=10; without the macro, stall_cycles_o=0.

Source files
------------

// File: rtl/c910_axi_txn_limiter.sv
// Outstanding-transaction limiter for the C910 AXI read/write address channels,
// split into cacheable and non-cacheable classes, with a flush/quiesce handshake.
// Optional stall statistics are enabled by defining C910_TXN_STATS_EN.
module c910_axi_txn_limiter #(
    parameter int AxiIdWidth = 8,
    parameter int NcIdBit    = 7,
    parameter int MaxRdC     = 28,
    parameter int MaxRdNc    = 8,
    parameter int MaxWrC     = 32,
    parameter int MaxWrNc    = 8,
    localparam int RdCW      = $clog2(MaxRdC + 1),
    localparam int RdNcW     = $clog2(MaxRdNc + 1),
    localparam int WrCW      = $clog2(MaxWrC + 1),
    localparam int WrNcW     = $clog2(MaxWrNc + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [AxiIdWidth-1:0] ar_id_i,
    output logic                  ar_valid_o,
    input  logic                  ar_ready_i,
    input  logic                  r_valid_i,
    input  logic                  r_ready_i,
    input  logic                  r_last_i,
    input  logic [AxiIdWidth-1:0] r_id_i,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [AxiIdWidth-1:0] aw_id_i,
    output logic                  aw_valid_o,
    input  logic                  aw_ready_i,
    input  logic                  b_valid_i,
    input  logic                  b_ready_i,
    input  logic [AxiIdWidth-1:0] b_id_i,
    input  logic                  flush_req_i,
    output logic                  flush_ack_o,
    output logic                  err_o,
    output logic [RdCW-1:0]       rd_cnt_c_o,
    output logic [RdNcW-1:0]      rd_cnt_nc_o,
    output logic [WrCW-1:0]       wr_cnt_c_o,
    output logic [WrNcW-1:0]      wr_cnt_nc_o,
    output logic [31:0]           stall_cycles_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } flush_state_e;

    flush_state_e state_reg;
    logic         flush_ack_reg;
    logic         err_reg;

    logic ar_nc, r_nc, aw_nc, b_nc;
    logic ar_block, aw_block;
    logic ar_fire, r_done, aw_fire, b_fire;
    logic all_zero;
    logic [3:0] cnt_inc, cnt_dec, cnt_full, cnt_underflow;

    // Only the class bit of each ID matters here.
    logic unused_id_bits;
    assign unused_id_bits = ^{ar_id_i, r_id_i, aw_id_i, b_id_i};

    assign ar_nc = ar_id_i[NcIdBit];
    assign r_nc  = r_id_i[NcIdBit];
    assign aw_nc = aw_id_i[NcIdBit];
    assign b_nc  = b_id_i[NcIdBit];

    assign ar_block = (ar_nc ? cnt_full[1] : cnt_full[0]) | (state_reg != IDLE);
    assign aw_block = (aw_nc ? cnt_full[3] : cnt_full[2]) | (state_reg != IDLE);

    assign ar_valid_o = ar_valid_i & ~ar_block;
    assign ar_ready_o = ar_ready_i & ~ar_block;
    assign aw_valid_o = aw_valid_i & ~aw_block;
    assign aw_ready_o = aw_ready_i & ~aw_block;

    assign ar_fire = ar_valid_o & ar_ready_i;
    assign aw_fire = aw_valid_o & aw_ready_i;
    assign r_done  = r_valid_i & r_ready_i & r_last_i;
    assign b_fire  = b_valid_i & b_ready_i;

    // Counter index: 0 = read C, 1 = read NC, 2 = write C, 3 = write NC.
    assign cnt_inc = {aw_fire & aw_nc, aw_fire & ~aw_nc, ar_fire & ar_nc, ar_fire & ~ar_nc};
    assign cnt_dec = {b_fire & b_nc, b_fire & ~b_nc, r_done & r_nc, r_done & ~r_nc};

    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
        localparam int M = (gi == 0) ? MaxRdC : (gi == 1) ? MaxRdNc :
                           (gi == 2) ? MaxWrC : MaxWrNc;
        localparam int W = $clog2(M + 1);
        localparam logic [W-1:0] MaxV = W'(M);
        logic [W-1:0] cnt_reg;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_reg <= '0;
            end else if (cnt_inc[gi] && !cnt_dec[gi] && cnt_reg != MaxV) begin
                cnt_reg <= cnt_reg + W'(1);
            end else if (cnt_dec[gi] && !cnt_inc[gi] && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - W'(1);
            end
        end

        assign cnt_full[gi]      = (cnt_reg == MaxV);
        assign cnt_underflow[gi] = cnt_dec[gi] & ~cnt_inc[gi] & (cnt_reg == '0);

        if (gi == 0) begin : g_o
            assign rd_cnt_c_o = cnt_reg;
        end else if (gi == 1) begin : g_o
            assign rd_cnt_nc_o = cnt_reg;
        end else if (gi == 2) begin : g_o
            assign wr_cnt_c_o = cnt_reg;
        end else begin : g_o
            assign wr_cnt_nc_o = cnt_reg;
        end
    end

    assign all_zero = ~|{rd_cnt_c_o, rd_cnt_nc_o, wr_cnt_c_o, wr_cnt_nc_o};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_reg <= 1'b0;
        end else if (|cnt_underflow) begin
            err_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            flush_ack_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (flush_req_i) state_reg <= DRAIN;
                end
                DRAIN: begin
                    if (all_zero) begin
                        state_reg     <= DONE;
                        flush_ack_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (!flush_req_i) begin
                        state_reg     <= IDLE;
                        flush_ack_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    flush_ack_reg <= 1'b0;
                end
            endcase
        end
    end

    assign flush_ack_o = flush_ack_reg;
    assign err_o       = err_reg;

`ifdef C910_TXN_STATS_EN
    logic [31:0] stall_reg;

    // Saturating count of cycles in which any requester was held off.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_reg <= '0;
        end else if (((ar_valid_i & ar_block) | (aw_valid_i & aw_block)) &&
                     stall_reg != 32'hFFFF_FFFF) begin
            stall_reg <= stall_reg + 32'd1;
        end
    end

    assign stall_cycles_o = stall_reg;
`else
    assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_c910_axi_txn_limiter.sv
// Self-checking bench for c910_axi_txn_limiter: a vector table for single-cycle
// behaviour plus hand sequences for limits, bursts, flush, underflow and reset.
module tb_c910_axi_txn_limiter;

`ifdef C910_TXN_STATS_EN
    localparam int STALL_EXP = 10;
`else
    localparam int STALL_EXP = 0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       ar_valid_i, ar_ready_o, ar_valid_o, ar_ready_i;
    logic [7:0] ar_id_i;
    logic       r_valid_i, r_ready_i, r_last_i;
    logic [7:0] r_id_i;
    logic       aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
    logic [7:0] aw_id_i;
    logic       b_valid_i, b_ready_i;
    logic [7:0] b_id_i;
    logic       flush_req_i, flush_ack_o, err_o;
    logic [4:0] rd_cnt_c_o;
    logic [3:0] rd_cnt_nc_o;
    logic [5:0] wr_cnt_c_o;
    logic [3:0] wr_cnt_nc_o;
    logic [31:0] stall_cycles_o;

    always #5 clk_i = ~clk_i;

    c910_axi_txn_limiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i), .r_id_i(r_id_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .b_valid_i(b_valid_i), .b_ready_i(b_ready_i), .b_id_i(b_id_i),
        .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o), .err_o(err_o),
        .rd_cnt_c_o(rd_cnt_c_o), .rd_cnt_nc_o(rd_cnt_nc_o),
        .wr_cnt_c_o(wr_cnt_c_o), .wr_cnt_nc_o(wr_cnt_nc_o),
        .stall_cycles_o(stall_cycles_o)
    );

    localparam int S_RDC = 0, S_RDNC = 1, S_WRC = 2, S_WRNC = 3, S_ERR = 4,
                   S_ACK = 5, S_STALL = 6;

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    typedef struct {
        logic ar_v, ar_nc, ar_rdy, r_v, r_last, r_nc, aw_v, aw_nc, aw_rdy, b_v, b_nc;
        logic e_arvo, e_awvo;
        int   e_rdc, e_rdnc, e_wrc, e_wrnc;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    exp_t sb_q[$];
    vec_t vecs[11];

    function automatic logic [31:0] dut_val(input int sel);
        case (sel)
            S_RDC:   return 32'(rd_cnt_c_o);
            S_RDNC:  return 32'(rd_cnt_nc_o);
            S_WRC:   return 32'(wr_cnt_c_o);
            S_WRNC:  return 32'(wr_cnt_nc_o);
            S_ERR:   return 32'(err_o);
            S_ACK:   return 32'(flush_ack_o);
            S_STALL: return stall_cycles_o;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [7:0] mk_id(input logic nc);
        logic [7:0] t;
        t    = 8'($urandom_range(0, 255));
        t[7] = nc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic expect_reg(input int sel, input logic [31:0] val, input string name);
        exp_t e;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.name, dut_val(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        ar_valid_i = 0; ar_ready_i = 0; ar_id_i = '0;
        r_valid_i = 0; r_ready_i = 0; r_last_i = 0; r_id_i = '0;
        aw_valid_i = 0; aw_ready_i = 0; aw_id_i = '0;
        b_valid_i = 0; b_ready_i = 0; b_id_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        flush_req_i = 0;
        rst_ni = 0;
        #1;
        chk("rst_rd_c", 32'(rd_cnt_c_o), 0);
        chk("rst_rd_nc", 32'(rd_cnt_nc_o), 0);
        chk("rst_wr_c", 32'(wr_cnt_c_o), 0);
        chk("rst_wr_nc", 32'(wr_cnt_nc_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_ack", 32'(flush_ack_o), 0);
        chk("rst_stall", stall_cycles_o, 0);
        tick();
        tick();
        rst_ni = 1;
    endtask

    task automatic send_ar(input logic nc, input int n);
        for (int k = 0; k < n; k++) begin
            ar_valid_i = 1; ar_ready_i = 1; ar_id_i = mk_id(nc);
            tick();
        end
        ar_valid_i = 0; ar_ready_i = 0;
    endtask

    initial begin
        //           ar_v nc rdy r_v lst nc aw_v nc rdy b_v nc arvo awvo rdc rdnc wrc wrnc
        vecs[0]  = '{0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0};
        vecs[1]  = '{1, 0, 1,  0, 0, 0,  0, 0, 0,  0, 0,  1, 0,  1, 0, 0, 0};
        vecs[2]  = '{1, 1, 1,  0, 0, 0,  1, 0, 1,  0, 0,  1, 1,  1, 1, 1, 0};
        vecs[3]  = '{1, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0,  1, 0,  1, 1, 1, 0};
        vecs[4]  = '{0, 0, 0,  1, 0, 0,  0, 0, 0,  0, 0,  0, 0,  1, 1, 1, 0};
        vecs[5]  = '{1, 0, 1,  1, 1, 0,  0, 0, 0,  0, 0,  1, 0,  1, 1, 1, 0};
        vecs[6]  = '{0, 0, 0,  1, 1, 1,  0, 0, 0,  0, 0,  0, 0,  1, 0, 1, 0};
        vecs[7]  = '{0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0,  0, 0,  1, 0, 0, 0};
        vecs[8]  = '{0, 0, 0,  0, 0, 0,  1, 1, 1,  0, 0,  0, 1,  1, 0, 0, 1};
        vecs[9]  = '{0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 1,  0, 0,  1, 0, 0, 0};
        vecs[10] = '{1, 1, 0,  1, 1, 0,  0, 0, 0,  0, 0,  1, 0,  0, 0, 0, 0};

        clear_inputs();
        flush_req_i = 0;
        rst_ni = 1;
        #2;
        do_reset();

        // Single-cycle vectors starting from reset
        for (int i = 0; i < 11; i++) begin
            ar_valid_i = vecs[i].ar_v; ar_ready_i = vecs[i].ar_rdy; ar_id_i = mk_id(vecs[i].ar_nc);
            r_valid_i = vecs[i].r_v; r_ready_i = 1; r_last_i = vecs[i].r_last; r_id_i = mk_id(vecs[i].r_nc);
            aw_valid_i = vecs[i].aw_v; aw_ready_i = vecs[i].aw_rdy; aw_id_i = mk_id(vecs[i].aw_nc);
            b_valid_i = vecs[i].b_v; b_ready_i = 1; b_id_i = mk_id(vecs[i].b_nc);
            #1;
            chk($sformatf("vec%0d_ar_valid_o", i), 32'(ar_valid_o), 32'(vecs[i].e_arvo));
            chk($sformatf("vec%0d_aw_valid_o", i), 32'(aw_valid_o), 32'(vecs[i].e_awvo));
            expect_reg(S_RDC, vecs[i].e_rdc, $sformatf("vec%0d_rd_c", i));
            expect_reg(S_RDNC, vecs[i].e_rdnc, $sformatf("vec%0d_rd_nc", i));
            expect_reg(S_WRC, vecs[i].e_wrc, $sformatf("vec%0d_wr_c", i));
            expect_reg(S_WRNC, vecs[i].e_wrnc, $sformatf("vec%0d_wr_nc", i));
            expect_reg(S_ERR, 0, $sformatf("vec%0d_err", i));
            tick();
            sb_check();
        end

        // Read limit: 28 cacheable ARs fill the class, then stall cycles
        do_reset();
        send_ar(0, 28);
        expect_reg(S_RDC, 28, "lim_rd_c_full");
        expect_reg(S_STALL, 0, "lim_stall_before");
        sb_check();
        ar_valid_i = 1; ar_ready_i = 1; ar_id_i = mk_id(0);
        aw_valid_i = 1; aw_ready_i = 0; aw_id_i = mk_id(0);
        #1;
        chk("lim_ar_valid_o_blocked", 32'(ar_valid_o), 0);
        chk("lim_ar_ready_o_blocked", 32'(ar_ready_o), 0);
        chk("lim_aw_valid_o_free", 32'(aw_valid_o), 1);
        for (int k = 0; k < 10; k++) tick();
        clear_inputs();
        expect_reg(S_RDC, 28, "lim_rd_c_held");
        expect_reg(S_STALL, STALL_EXP, "lim_stall_cycles");
        sb_check();
        ar_valid_i = 1; ar_ready_i = 1; ar_id_i = mk_id(1);
        #1;
        chk("lim_nc_ar_valid_o", 32'(ar_valid_o), 1);
        tick();
        clear_inputs();
        expect_reg(S_RDNC, 1, "lim_rd_nc");
        expect_reg(S_RDC, 28, "lim_rd_c_after_nc");
        expect_reg(S_STALL, STALL_EXP, "lim_stall_after_nc");
        sb_check();

        // R burst: last beat without r_ready does nothing; only the last beat decrements
        r_valid_i = 1; r_ready_i = 0; r_last_i = 1; r_id_i = mk_id(0);
        tick();
        expect_reg(S_RDC, 28, "burst_no_ready");
        sb_check();
        for (int b = 0; b < 4; b++) begin
            r_valid_i = 1; r_ready_i = 1; r_last_i = (b == 3); r_id_i = mk_id(0);
            tick();
            expect_reg(S_RDC, (b == 3) ? 27 : 28, $sformatf("burst_beat%0d", b));
            sb_check();
        end
        clear_inputs();
        ar_valid_i = 1; ar_ready_i = 1; ar_id_i = mk_id(0);
        #1;
        chk("burst_ar_ready_o_reopened", 32'(ar_ready_o), 1);
        clear_inputs();

        // Same-cycle accept and release at count 5
        do_reset();
        send_ar(0, 5);
        expect_reg(S_RDC, 5, "simul_pre");
        sb_check();
        ar_valid_i = 1; ar_ready_i = 1; ar_id_i = mk_id(0);
        r_valid_i = 1; r_ready_i = 1; r_last_i = 1; r_id_i = mk_id(0);
        tick();
        clear_inputs();
        expect_reg(S_RDC, 5, "simul_post");
        expect_reg(S_ERR, 0, "simul_err");
        sb_check();

        // Flush with 3 outstanding writes and an in-flight AR
        do_reset();
        aw_valid_i = 1; aw_ready_i = 1;
        aw_id_i = mk_id(0); tick();
        aw_id_i = mk_id(0); tick();
        aw_id_i = mk_id(1); tick();
        clear_inputs();
        expect_reg(S_WRC, 2, "flush_wr_c_pre");
        expect_reg(S_WRNC, 1, "flush_wr_nc_pre");
        sb_check();
        ar_valid_i = 1; ar_ready_i = 0; ar_id_i = mk_id(0);
        flush_req_i = 1;
        #1;
        chk("flush_ar_valid_o_idle", 32'(ar_valid_o), 1);
        tick();
        chk("flush_ar_valid_o_drain", 32'(ar_valid_o), 0);
        ar_ready_i = 1;
        aw_valid_i = 1; aw_ready_i = 1; aw_id_i = mk_id(0);
        #1;
        chk("flush_aw_valid_o_drain", 32'(aw_valid_o), 0);
        chk("flush_aw_ready_o_drain", 32'(aw_ready_o), 0);
        chk("flush_ack_drain", 32'(flush_ack_o), 0);
        tick();
        clear_inputs();
        expect_reg(S_RDC, 0, "flush_no_ar_counted");
        expect_reg(S_WRC, 2, "flush_no_aw_counted");
        expect_reg(S_ACK, 0, "flush_ack_pending");
        sb_check();
        b_valid_i = 1; b_ready_i = 1;
        b_id_i = mk_id(0); tick();
        b_id_i = mk_id(0); tick();
        b_id_i = mk_id(1); tick();
        clear_inputs();
        expect_reg(S_WRC, 0, "flush_wr_c_drained");
        expect_reg(S_WRNC, 0, "flush_wr_nc_drained");
        expect_reg(S_ACK, 0, "flush_ack_same_cycle");
        sb_check();
        tick();
        expect_reg(S_ACK, 1, "flush_ack_next_cycle");
        sb_check();
        ar_valid_i = 1; ar_ready_i = 1; ar_id_i = mk_id(1);
        #1;
        chk("flush_ar_blocked_done", 32'(ar_valid_o), 0);
        flush_req_i = 0;
        tick();
        expect_reg(S_ACK, 0, "flush_ack_released");
        sb_check();
        chk("flush_ar_valid_o_idle_again", 32'(ar_valid_o), 1);
        clear_inputs();

        // Underflow is sticky and the counter stays at zero
        do_reset();
        b_valid_i = 1; b_ready_i = 1; b_id_i = mk_id(1);
        tick();
        clear_inputs();
        expect_reg(S_ERR, 1, "uflow_err_set");
        expect_reg(S_WRNC, 0, "uflow_wr_nc_zero");
        sb_check();
        tick();
        tick();
        expect_reg(S_ERR, 1, "uflow_err_sticky");
        sb_check();

        // Reset mid-operation drops state; a late response underflows
        do_reset();
        send_ar(0, 1);
        expect_reg(S_RDC, 1, "midrst_pre");
        sb_check();
        #3;
        rst_ni = 0;
        #1;
        chk("midrst_async_clear", 32'(rd_cnt_c_o), 0);
        tick();
        rst_ni = 1;
        r_valid_i = 1; r_ready_i = 1; r_last_i = 1; r_id_i = mk_id(0);
        tick();
        clear_inputs();
        expect_reg(S_ERR, 1, "midrst_late_r_err");
        expect_reg(S_RDC, 0, "midrst_rd_c_zero");
        sb_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
